// File: rtl/submean_pkg.sv
// Shared helpers for the moving-average DC-removal block:
// window/accumulator sizing and the saturating narrow.
package submean_pkg;

   localparam int MAX_DW = 32;

   function automatic int win(input int lw);
      return 1 << lw;
   endfunction

   function automatic int acc_w(input int dw, input int lw);
      return dw + lw;
   endfunction

   // Clamp a wide signed value into a dw-bit signed range.
   function automatic logic signed [MAX_DW-1:0] sat_sN(
      input logic signed [MAX_DW:0] v,
      input int dw
   );
      localparam logic [MAX_DW:0] ONE = (MAX_DW+1)'(1);
      logic signed [MAX_DW:0] hi;
      logic signed [MAX_DW:0] lo;
      hi = $signed((ONE << (dw - 1)) - ONE);
      lo = -hi - $signed(ONE);
      if (v > hi)
         return hi[MAX_DW-1:0];
      else if (v < lo)
         return lo[MAX_DW-1:0];
      else
         return v[MAX_DW-1:0];
   endfunction

endpackage

// File: rtl/submean_chan.sv
// One channel lane: ring buffer, running sum and the
// two-stage subtract-and-saturate datapath.
module submean_chan
   import submean_pkg::*;
#(
   parameter int DW = 16,
   parameter int LW = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 take,
   input  logic                 full,
   input  logic                 upd,
   input  logic [LW-1:0]        wptr,
   input  logic signed [DW-1:0] x,
   output logic signed [DW-1:0] y
);

   localparam int W   = win(LW);
   localparam int ACC = acc_w(DW, LW);

   logic signed [DW-1:0]  ring [W];
   logic signed [ACC-1:0] sum;
   logic signed [ACC-1:0] sum_new;
   logic signed [DW-1:0]  old;
   logic signed [DW-1:0]  xr;
   logic signed [DW-1:0]  mr;
   logic signed [DW:0]    diff;
   logic signed [DW-1:0]  y_sat;

   assign old     = full ? ring[wptr] : '0;
   assign sum_new = sum + ACC'(x) - ACC'(old);
   assign diff    = {xr[DW-1], xr} - {mr[DW-1], mr};
   assign y_sat   = DW'(sat_sN((MAX_DW+1)'(diff), DW));

   // No reset on the storage: cnt gating hides stale entries.
   always_ff @(posedge clk) begin
      if (take)
         ring[wptr] <= x;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         sum <= '0;
      end else if (take) begin
         sum <= sum_new;
         xr  <= x;
         mr  <= sum_new[ACC-1:LW];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         y <= '0;
      else if (upd)
         y <= y_sat;
   end

endmodule

// File: rtl/submean_mc.sv
// Multi-channel moving-average DC removal; owns the shared
// write pointer, fill counter and valid pipeline.
module submean_mc
   import submean_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int LOG2_WIN   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic                         primed
);

   localparam int W  = win(LOG2_WIN);
   localparam int CW = LOG2_WIN + 1;

   logic [LOG2_WIN-1:0] wptr;
   logic [CW-1:0]       cnt;
   logic                v1;
   logic                take;
   logic                full;
   logic                upd;

   assign take = in_valid & ~flush & ~reset;
   assign full = (cnt == CW'(W));
   assign upd  = v1 & ~flush & ~reset;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr      <= '0;
         cnt       <= '0;
         v1        <= 1'b0;
         out_valid <= 1'b0;
         primed    <= 1'b0;
      end else begin
         out_valid <= v1;
         if (v1)
            primed <= 1'b1;
         v1 <= take && (cnt >= CW'(W - 1));
         if (take) begin
            wptr <= wptr + LOG2_WIN'(1);
            if (!full)
               cnt <= cnt + CW'(1);
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      submean_chan #(
         .DW (DATA_WIDTH),
         .LW (LOG2_WIN)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .flush (flush),
         .take  (take),
         .full  (full),
         .upd   (upd),
         .wptr  (wptr),
         .x     (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .y     (out_data[c*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule
